latch_bank_ctrl: RTL and testbench

LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

---
 rtl/latch_bank_ctrl_pkg.sv | 25 ++
 rtl/latch_bank_ctrl_if.sv | 31 +++
 rtl/latch_bank_ctrl_rr_arb2.sv | 32 +++
 rtl/latch_bank_ctrl.sv | 133 +++++++++++++
 tb/tb_latch_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/latch_bank_ctrl_pkg.sv
// Shared types and default sizing for the latch bank write controller.
// Holds the controller state encoding and the phase-count defaults.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DEF_DW        = 8;
  localparam int DEF_NWORD     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Two requester write ports plus the latch-bank drive bus.
// master = requester/bench side, slave = controller side.
interface latch_bank_ctrl_if #(
  parameter int DW    = latch_ctrl_pkg::DEF_DW,
  parameter int NWORD = latch_ctrl_pkg::DEF_NWORD
);
  localparam int AW = (NWORD > 1) ? $clog2(NWORD) : 1;

  logic             req_a;
  logic [AW-1:0]    addr_a;
  logic [DW-1:0]    data_a;
  logic             ack_a;
  logic             req_b;
  logic [AW-1:0]    addr_b;
  logic [DW-1:0]    data_b;
  logic             ack_b;
  logic [NWORD-1:0] lat_en;
  logic [DW-1:0]    lat_d;
  logic             busy;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  ack_a, ack_b, lat_en, lat_d, busy
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output ack_a, ack_b, lat_en, lat_d, busy
  );

endinterface

// File: rtl/latch_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, pointer updates on a taken grant.
// Pointer favours A out of reset and moves to the loser after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       gnt_vld_o,
  output logic [1:0] gnt_oh_o
);

  logic ptr_q;
  logic ptr_d;
  logic gnt_idx;

  // ptr_q = 1 means B wins a tie; a lone request always wins
  always_comb begin
    gnt_idx   = req_i[1] & (~req_i[0] | ptr_q);
    gnt_vld_o = |req_i;
    gnt_oh_o  = gnt_vld_o ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    ptr_d     = (adv_i && gnt_vld_o) ? ~gnt_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Writes one latch word per grant: setup, enable pulse, hold, then 4-phase ack.
// Requests are sampled only in IDLE; a waiting requester sees ack low until served.
module latch_bank_ctrl #(
  parameter int DW        = latch_ctrl_pkg::DEF_DW,
  parameter int NWORD     = latch_ctrl_pkg::DEF_NWORD,
  parameter int SETUP_CYC = latch_ctrl_pkg::DEF_SETUP_CYC,
  parameter int PULSE_CYC = latch_ctrl_pkg::DEF_PULSE_CYC,
  parameter int HOLD_CYC  = latch_ctrl_pkg::DEF_HOLD_CYC
) (
  input logic             CLK,
  input logic             RN,
  latch_bank_ctrl_if.slave bus
);
  import latch_ctrl_pkg::*;

  localparam int AW = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t PULSE_LD = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);

  state_e           state_q;
  cnt_t             cnt_q;
  logic [1:0]       gnt_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    lat_d_q;
  logic [NWORD-1:0] lat_en_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic             busy_q;

  logic             arb_vld;
  logic [1:0]       arb_oh;
  logic [NWORD-1:0] dec;
  logic             gnt_req;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst_n     (RN),
    .req_i     ({bus.req_b, bus.req_a}),
    .adv_i     (state_q == ST_IDLE),
    .gnt_vld_o (arb_vld),
    .gnt_oh_o  (arb_oh)
  );

  always_comb begin
    dec         = '0;
    dec[addr_q] = 1'b1;
  end

  // Live req of whichever port owns the current write; used only for the ack handshake
  assign gnt_req = (gnt_q[0] & bus.req_a) | (gnt_q[1] & bus.req_b);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_q   <= arb_oh;
            addr_q  <= arb_oh[1] ? bus.addr_b : bus.addr_a;
            lat_d_q <= arb_oh[1] ? bus.data_b : bus.data_a;
            cnt_q   <= SETUP_LD;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            lat_en_q <= dec;
            cnt_q    <= PULSE_LD;
            state_q  <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            lat_en_q <= '0;
            cnt_q    <= HOLD_LD;
            state_q  <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            ack_a_q <= gnt_q[0];
            ack_b_q <= gnt_q[1];
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          // A req dropped early still gets exactly one ack cycle here
          if (!gnt_req) begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          lat_en_q <= '0;
          ack_a_q  <= 1'b0;
          ack_b_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.lat_en = lat_en_q;
  assign bus.lat_d  = lat_d_q;
  assign bus.ack_a  = ack_a_q;
  assign bus.ack_b  = ack_b_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor checks timing and data.
module tb_latch_bank_ctrl;

  logic CLK = 1'b0;
  logic rn0 = 1'b1;
  logic rn1 = 1'b1;
  always #5 CLK = ~CLK;

  latch_bank_ctrl_if bus0 ();
  latch_bank_ctrl_if bus1 ();

  latch_bank_ctrl dut0 (.CLK(CLK), .RN(rn0), .bus(bus0));
  latch_bank_ctrl #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (.CLK(CLK), .RN(rn1), .bus(bus1));

  typedef struct {
    int         inst;
    bit         port_b;
    logic [7:0] en;
    logic [7:0] dat;
    int         ack_len;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   S[2] = '{1, 3};
  int   P[2] = '{2, 1};
  int   H[2] = '{1, 2};

  bit         act[2];
  exp_t       cur[2];
  int         k_edge[2];
  int         en_st[2];
  int         ack_st[2];
  logic       prev_busy[2];
  logic [7:0] prev_en[2];
  logic [1:0] prev_ack[2];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int actual, input int expv);
    n_chk++;
    if (actual != expv) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, actual, expv, cyc);
    end
  endtask

  task automatic push(input int inst, input bit b, input logic [7:0] en, input logic [7:0] d, input int len);
    exp_t e;
    e.inst = inst; e.port_b = b; e.en = en; e.dat = d; e.ack_len = len;
    sbq.push_back(e);
  endtask

  task automatic set_port(input int inst, input bit b, input logic r, input logic [2:0] a, input logic [7:0] d);
    if (inst == 0) begin
      if (b) begin bus0.req_b = r; bus0.addr_b = a; bus0.data_b = d; end
      else   begin bus0.req_a = r; bus0.addr_a = a; bus0.data_a = d; end
    end else begin
      if (b) begin bus1.req_b = r; bus1.addr_b = a; bus1.data_b = d; end
      else   begin bus1.req_a = r; bus1.addr_a = a; bus1.data_a = d; end
    end
  endtask

  function automatic logic get_ack(input int inst, input bit b);
    if (inst == 0) return b ? bus0.ack_b : bus0.ack_a;
    return b ? bus1.ack_b : bus1.ack_a;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bus0.busy : bus1.busy;
  endfunction

  // extra: cycles req stays high after ack is seen; early: drop req right after grant
  task automatic drive(input int inst, input bit b, input logic [2:0] a, input logic [7:0] d,
                       input int extra, input bit early, input bit tog);
    bit got = 1'b0;
    set_port(inst, b, 1'b1, a, d);
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge CLK);
      if (inst == 0 && !rn0) begin
        set_port(inst, b, 1'b0, a, d);
        return;
      end
      if (get_ack(inst, b)) got = 1'b1;
      else if (get_busy(inst)) begin
        if (early) set_port(inst, b, 1'b0, a, d);
        else if (tog) set_port(inst, b, 1'b1, 3'($urandom), 8'($urandom));
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: inst %0d port %0d got no ack, required ack within 300 cycles", inst, b);
      set_port(inst, b, 1'b0, a, d);
      return;
    end
    if (!early) begin
      repeat (extra) @(negedge CLK);
      set_port(inst, b, 1'b0, a, d);
    end
    @(negedge CLK);
  endtask

  task automatic mon(input int i, input logic rn, input logic busy, input logic [7:0] en,
                     input logic [7:0] d, input logic aa, input logic ab);
    logic [1:0] ackv;
    ackv = {ab, aa};
    if (!rn) begin
      act[i] = 1'b0; prev_busy[i] = 1'b0; prev_en[i] = '0; prev_ack[i] = '0;
      return;
    end
    if (busy && !prev_busy[i]) begin
      if (sbq.size() == 0 || sbq[0].inst != i) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: inst %0d started a write, required none pending", i);
      end else begin
        cur[i] = sbq.pop_front();
        k_edge[i] = cyc;
        act[i] = 1'b1;
      end
    end
    if (act[i]) begin
      if (busy) chk($sformatf("lat_d_stable%0d", i), int'(d), int'(cur[i].dat));
      if (en != '0 && prev_en[i] == '0) begin
        chk($sformatf("en_start%0d", i), cyc - k_edge[i], S[i]);
        chk($sformatf("en_onehot%0d", i), int'(en), int'(cur[i].en));
        en_st[i] = cyc;
      end else if (en != '0 && en != prev_en[i]) begin
        chk($sformatf("en_change%0d", i), int'(en), int'(prev_en[i]));
      end
      if (en == '0 && prev_en[i] != '0) chk($sformatf("en_width%0d", i), cyc - en_st[i], P[i]);
      if (ackv != 2'b00 && prev_ack[i] == 2'b00) begin
        chk($sformatf("ack_time%0d", i), cyc - k_edge[i], S[i] + P[i] + H[i]);
        chk($sformatf("ack_port%0d", i), int'(ackv), cur[i].port_b ? 2 : 1);
        ack_st[i] = cyc;
      end
      if (ackv == 2'b00 && prev_ack[i] != 2'b00) begin
        chk($sformatf("ack_len%0d", i), cyc - ack_st[i], cur[i].ack_len);
        chk($sformatf("busy_clear%0d", i), int'(busy), 0);
        act[i] = 1'b0;
      end
    end
    prev_busy[i] = busy;
    prev_en[i]   = en;
    prev_ack[i]  = ackv;
  endtask

  always @(negedge CLK) begin
    mon(0, rn0, bus0.busy, bus0.lat_en, bus0.lat_d, bus0.ack_a, bus0.ack_b);
    mon(1, rn1, bus1.busy, bus1.lat_en, bus1.lat_d, bus1.ack_a, bus1.ack_b);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      set_port(i, 1'b0, 1'b0, 3'd0, 8'h00);
      set_port(i, 1'b1, 1'b0, 3'd0, 8'h00);
    end
    #2;
    rn0 = 1'b0;
    rn1 = 1'b0;
    #1;
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_lat_en", int'(bus0.lat_en), 0);
    chk("rst_lat_d", int'(bus0.lat_d), 0);
    chk("rst_acks", int'({bus0.ack_b, bus0.ack_a}), 0);
    chk("rst_lat_en1", int'(bus1.lat_en), 0);
    repeat (3) @(negedge CLK);
    rn0 = 1'b1;
    rn1 = 1'b1;
    @(negedge CLK);

    // contention after reset: A first, then B
    push(0, 1'b0, 8'h02, 8'h11, 2);
    push(0, 1'b1, 8'h80, 8'h22, 1);
    fork
      drive(0, 1'b0, 3'd1, 8'h11, 1, 1'b0, 1'b0);
      drive(0, 1'b1, 3'd7, 8'h22, 0, 1'b0, 1'b0);
    join

    // single write, addr 5 data A5
    push(0, 1'b0, 8'h20, 8'hA5, 3);
    drive(0, 1'b0, 3'd5, 8'hA5, 2, 1'b0, 1'b0);

    // pointer now favours B: B then A
    push(0, 1'b1, 8'h08, 8'h33, 1);
    push(0, 1'b0, 8'h01, 8'h44, 1);
    fork
      drive(0, 1'b0, 3'd0, 8'h44, 0, 1'b0, 1'b0);
      drive(0, 1'b1, 3'd3, 8'h33, 0, 1'b0, 1'b0);
    join

    // port A toggles addr/data every cycle after grant
    push(0, 1'b0, 8'h40, 8'h5A, 1);
    drive(0, 1'b0, 3'd6, 8'h5A, 0, 1'b0, 1'b1);

    // req_b dropped in SETUP
    push(0, 1'b1, 8'h02, 8'hC3, 1);
    drive(0, 1'b1, 3'd1, 8'hC3, 0, 1'b1, 1'b0);

    // reset while lat_en = 0x04
    push(0, 1'b0, 8'h04, 8'h3C, 1);
    fork
      drive(0, 1'b0, 3'd2, 8'h3C, 0, 1'b0, 1'b0);
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge CLK);
          if (bus0.lat_en == 8'h04) break;
        end
        chk("abort_en_seen", int'(bus0.lat_en), 4);
        #2 rn0 = 1'b0;
        #1;
        chk("abort_lat_en", int'(bus0.lat_en), 0);
        chk("abort_acks", int'({bus0.ack_b, bus0.ack_a}), 0);
        chk("abort_busy", int'(bus0.busy), 0);
        chk("abort_lat_d", int'(bus0.lat_d), 0);
        @(negedge CLK);
        #2 rn0 = 1'b1;
      end
    join
    @(negedge CLK);

    // pointer back to A after reset
    push(0, 1'b0, 8'h01, 8'h66, 1);
    push(0, 1'b1, 8'h10, 8'h77, 1);
    fork
      drive(0, 1'b0, 3'd0, 8'h66, 0, 1'b0, 1'b0);
      drive(0, 1'b1, 3'd4, 8'h77, 0, 1'b0, 1'b0);
    join

    // phase sweep instance: setup 3, pulse 1, hold 2
    push(1, 1'b0, 8'h08, 8'h99, 1);
    drive(1, 1'b0, 3'd3, 8'h99, 0, 1'b0, 1'b1);
    push(1, 1'b1, 8'h80, 8'hE7, 3);
    drive(1, 1'b1, 3'd7, 8'hE7, 2, 1'b0, 1'b0);

    repeat (5) @(negedge CLK);
    chk("sb_drain", sbq.size(), 0);
    chk("final_busy", int'({bus1.busy, bus0.busy}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
